// File: rtl/clam_pkg.sv
// Shared definitions for the pipelined approximate/exact multiplier: mode
// encoding, partial-product column mask and parameter range helpers.
package clam_pkg;

  localparam logic MODE_EXACT      = 1'b0;
  localparam logic MODE_APPROX     = 1'b1;
  localparam int   MAX_PIPE_STAGES = 4;

  // A partial-product bit a[i]&b[j] lands in column i+j; approximate mode keeps it only at or above k.
  function automatic logic pp_keep(input int i, input int j, input int k);
    return (i + j) >= k;
  endfunction

  function automatic logic pipe_stages_ok(input int s);
    return (s >= 0) && (s <= MAX_PIPE_STAGES);
  endfunction

  function automatic logic trunc_k_ok(input int k, input int w);
    return (k >= 0) && (k < 2 * w);
  endfunction

endpackage

// File: rtl/clam_pp_array.sv
// Combinational partial-product generator. Row j holds a&b[j] shifted to
// column j; in approximate mode bits below column TRUNC_K are forced to zero.
module clam_pp_array
  import clam_pkg::*;
#(
  parameter int W       = 8,
  parameter int TRUNC_K = 4
) (
  input  logic [W-1:0]          a_i,
  input  logic [W-1:0]          b_i,
  input  logic                  mode_i,
  output logic [W-1:0][2*W-1:0] pp_o
);

  always_comb begin
    pp_o = '0;
    for (int j = 0; j < W; j++) begin
      for (int i = 0; i < W; i++) begin
        if ((mode_i != MODE_APPROX) || pp_keep(i, j, TRUNC_K)) begin
          pp_o[j][i+j] = a_i[i] & b_i[j];
        end
      end
    end
  end

endmodule

// File: rtl/clam_mult_pipe.sv
// Pipelined unsigned WxW multiplier with per-transaction exact/approximate
// mode, valid/ready flow control, sideband tag and completed-result counter.
module clam_mult_pipe
  import clam_pkg::*;
#(
  parameter int W           = 8,
  parameter int PIPE_STAGES = 1,
  parameter int TRUNC_K     = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             mode_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   s_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             mode_out,
  output logic [31:0]      done_cnt
);

  typedef logic [W-1:0][2*W-1:0] rows_t;

  if (!pipe_stages_ok(PIPE_STAGES)) begin : g_bad_stages
    $error("clam_mult_pipe: PIPE_STAGES must lie in 0..4");
  end
  if (!trunc_k_ok(TRUNC_K, W)) begin : g_bad_trunc
    $error("clam_mult_pipe: TRUNC_K must lie in 0..2W-1");
  end

  // One level of a pairwise adder tree; once a single row remains it passes through unchanged.
  function automatic rows_t fold_pairs(input rows_t rows);
    rows_t r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[i/2] = r[i/2] + rows[i];
    end
    return r;
  endfunction

  function automatic logic [2*W-1:0] sum_rows(input rows_t rows);
    logic [2*W-1:0] acc;
    acc = '0;
    for (int i = 0; i < W; i++) begin
      acc = acc + rows[i];
    end
    return acc;
  endfunction

  logic en;
  logic out_valid_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Input register
  logic             vld_in_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             mode_in_q;
  logic [TAG_W-1:0] tag_in_q;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst)     vld_in_q <= 1'b0;
    else if (en) vld_in_q <= in_valid;
  end

  always_ff @(posedge clk_100M) begin
    if (en && in_valid) begin
      a_q       <= a_in;
      b_q       <= b_in;
      mode_in_q <= mode_in;
      tag_in_q  <= tag_in;
    end
  end

  rows_t pp_rows;

  clam_pp_array #(
    .W       (W),
    .TRUNC_K (TRUNC_K)
  ) u_pp (
    .a_i    (a_q),
    .b_i    (b_q),
    .mode_i (mode_in_q),
    .pp_o   (pp_rows)
  );

  // Compute stages: stage 1 registers the masked partial products, later stages fold them
  for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_st
    rows_t            rows_d;
    logic             vld_d;
    logic             mode_d;
    logic [TAG_W-1:0] tag_d;
    rows_t            rows_q;
    logic             vld_q;
    logic             mode_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 1) begin : g_first
      assign rows_d = pp_rows;
      assign vld_d  = vld_in_q;
      assign mode_d = mode_in_q;
      assign tag_d  = tag_in_q;
    end else begin : g_next
      assign rows_d = fold_pairs(g_st[k-1].rows_q);
      assign vld_d  = g_st[k-1].vld_q;
      assign mode_d = g_st[k-1].mode_q;
      assign tag_d  = g_st[k-1].tag_q;
    end

    always_ff @(posedge clk_100M or posedge rst) begin
      if (rst)     vld_q <= 1'b0;
      else if (en) vld_q <= vld_d;
    end

    always_ff @(posedge clk_100M) begin
      if (en) begin
        rows_q <= rows_d;
        mode_q <= mode_d;
        tag_q  <= tag_d;
      end
    end
  end

  rows_t            fin_rows;
  logic             fin_vld;
  logic             fin_mode;
  logic [TAG_W-1:0] fin_tag;

  if (PIPE_STAGES == 0) begin : g_fin_comb
    assign fin_rows = pp_rows;
    assign fin_vld  = vld_in_q;
    assign fin_mode = mode_in_q;
    assign fin_tag  = tag_in_q;
  end else begin : g_fin_reg
    assign fin_rows = g_st[PIPE_STAGES].rows_q;
    assign fin_vld  = g_st[PIPE_STAGES].vld_q;
    assign fin_mode = g_st[PIPE_STAGES].mode_q;
    assign fin_tag  = g_st[PIPE_STAGES].tag_q;
  end

  // Output register: final reduction, held stable while the sink stalls
  logic [2*W-1:0]   s_d;
  logic [2*W-1:0]   s_q;
  logic [TAG_W-1:0] tag_q;
  logic             mode_q;
  logic [31:0]      done_d;
  logic [31:0]      done_q;

  assign s_d    = sum_rows(fin_rows);
  assign done_d = done_q + 32'd1;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      tag_q       <= '0;
      mode_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      if (en) begin
        out_valid_q <= fin_vld;
        s_q         <= s_d;
        tag_q       <= fin_tag;
        mode_q      <= fin_mode;
      end
      if (out_valid_q && out_ready) done_q <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s_out     = s_q;
  assign tag_out   = tag_q;
  assign mode_out  = mode_q;
  assign done_cnt  = done_q;

endmodule

// File: doc/clam_mult_pipe.md
Name: clam_mult_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 CLAM2 register wrapper.
- Performs unsigned WxW multiplication, either exact or approximate; the mode is selectable per transaction.
- Approximate mode drops every partial-product bit with column index below TRUNC_K.
- Adds valid/ready flow control, a configurable pipeline depth, a sideband tag and a completed-transaction counter.
- Sits between the input capture logic and the result sink in the 100 MHz domain (clk_100M from the clock generator).

Parameters:
- W, 8: operand width in bits; the product is 2W bits.
- PIPE_STAGES, 1: number of compute register stages between the input and output registers (0..4).
- TRUNC_K, 4: number of low partial-product columns dropped in approximate mode (0..2W-1).
- TAG_W, 4: width of the sideband tag carried alongside each operand pair.

Ports:
- clk_100M, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block can accept an operand pair this cycle.
- a_in, input, W: multiplicand, unsigned.
- b_in, input, W: multiplier, unsigned.
- mode_in, input, 1: 0 = exact, 1 = approximate.
- tag_in, input, TAG_W: user tag, returned unchanged with the result.
- out_valid, output, 1: result valid.
- out_ready, input, 1: sink accepts the result.
- s_out, output, 2W: product.
- tag_out, output, TAG_W: tag of this result.
- mode_out, output, 1: mode this result was computed with.
- done_cnt, output, 32: count of completed output handshakes.

Behaviour:
- Reset (rst=1, asynchronous):
  - All stage valid bits, out_valid, s_out, tag_out, mode_out and done_cnt are cleared to 0.
  - In-flight transactions are discarded.
  - in_ready goes to 1 after reset deasserts.
- Global advance enable: en = !out_valid | out_ready. in_ready = en (combinational).
- Input acceptance: occurs when in_valid & in_ready. a, b, mode and tag are captured into the input register.
- Pipeline advance:
  - When en=1, every stage (input register, PIPE_STAGES compute stages, output register) shifts forward by one.
  - A stage's valid bit follows its predecessor's valid bit; the input stage's valid bit follows the acceptance condition.
  - When en=0, all stages hold.
  - Bubbles are not collapsed.
- Latency: a pair accepted at edge t appears with out_valid=1 after edge t+PIPE_STAGES+1, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 result per cycle while out_ready=1.
- Arithmetic:
  - Exact: s = a*b, full 2W bits, no overflow.
  - Approximate: s = sum of a[i]&b[j] << (i+j) over all i,j with i+j >= TRUNC_K.
  - The result is therefore ≤ the exact product and never wraps.
  - TRUNC_K=0 makes approximate mode identical to exact mode.
  - mode travels with each transaction, so mixed-mode streams are legal back to back.
- Compute split:
  - Partial-product generation and truncation happen in the first compute stage.
  - Reduction is spread across the remaining stages.
  - When PIPE_STAGES=0, the whole computation lies between the input and output registers.
  - The bit-exact result is independent of PIPE_STAGES.
- Output holding: while out_valid=1 and out_ready=0, s_out, tag_out and mode_out hold stable.
- done_cnt: increments by 1 on each out_valid & out_ready cycle and wraps from 2^32-1 to 0.
- Simultaneous events:
  - Accept and output handshake in the same cycle is legal (steady streaming).
  - in_valid with in_ready=0: the input is ignored, and the source must hold it.

Decomposition:
- Package clam_pkg:
  - mode encoding constants MODE_EXACT=1'b0, MODE_APPROX=1'b1.
  - function pp_keep(i,j,k), returning the column mask (i+j >= k).
  - parameter legality checks (PIPE_STAGES range, TRUNC_K < 2W).
- Sub-module clam_pp_array:
  - Combinational partial-product generator with masking.
  - Parameters W and TRUNC_K; inputs a, b, mode; output is the array of 2W-wide rows.
  - The top level owns registers, handshake, reduction staging and done_cnt.

Test Plan:
1. W=8, K=4, mode=0, a=0xFF, b=0xFF → s_out=0xFE01. out_valid at accept+PIPE_STAGES+1; done_cnt=1 after handshake.
2. Same operands, mode=1 → s_out=0xFDD0 (49 dropped). a=3, b=3, mode=1 → s_out=0x0000. a=16, b=16, mode=1 → s_out=0x0100.
3. Stream 8 mixed-mode pairs, tags 0..7, out_ready=1 → one result per cycle, in order, tags match, done_cnt=8.
4. Hold out_ready=0 for 5 cycles with a full pipeline:
   - in_ready=0 throughout;
   - outputs stay stable;
   - after release, there is no loss or duplication.
5. Assert rst for 1 cycle mid-stream with 3 pairs in flight:
   - out_valid=0 and done_cnt=0 immediately;
   - no stale result appears afterwards;
   - the next accepted pair returns correctly.
6. Sweep all 65536 (a,b) pairs at W=8, K=0, mode=1 → every s_out equals a*b. Repeat at PIPE_STAGES=0 and 4.
